fifo_wr_arbiter: RTL and testbench

//   Shares the single write port of one fifo instance among N_REQ producers.

---
 rtl/fifo_wr_arbiter_pkg.sv | 16 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and constants for the FIFO write-port arbiter.
//   - arb_state_t : arbiter FSM state (ARB_IDLE picks a winner, ARB_OWN writes)
//   - STALL_CNT_W : width of the stall statistic output
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Starting at position ptr and walking
//   upward modulo N, returns the first index whose request bit is set.
// Ports
//   req   in  N       request vector
//   ptr   in  IW      search start position (0..N-1)
//   valid out 1       at least one request is set
//   idx   out IW      winning index (0 when valid=0)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Walk the offsets from farthest to nearest so the last hit written is the
  // one closest to ptr, which is the round-robin winner.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[IW'((int'(ptr) + k) % N)]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the single write port of one FIFO among N_REQ producers using
//   round-robin arbitration with bounded bursts. Stalls (without losing
//   ownership) while the FIFO reports full. One idle bubble per arbitration.
// Parameters
//   DATA_TYPE  FIFO word type
//   N_REQ      number of requesters (2..16)
//   MAX_BURST  max words written per grant (1..16)
// Ports
//   clk           in   clock, all state on rising edge
//   reset         in   asynchronous active-high reset
//   req           in   [N_REQ]   per-requester word-valid
//   req_data      in   DATA_TYPE [N_REQ] per-requester word
//   fifo_full     in   FIFO full flag
//   gnt           out  [N_REQ] one-hot, word of that requester written now
//   fifo_wr_en    out  FIFO write enable (= |gnt)
//   fifo_wr_data  out  word being written, '0 when not writing
//   busy          out  a requester currently owns the port
//   stall_cnt     out  [16] cycles the owner was blocked by fifo_full
// Configuration
//   FIFO_WR_ARB_STATS_EN : when defined, stall_cnt is a saturating counter;
//   otherwise it is tied to zero and no counter is built.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter type DATA_TYPE = logic [1:0],
  parameter int  N_REQ     = 4,
  parameter int  MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  DATA_TYPE               req_data [N_REQ],
  input  logic                   fifo_full,
  output logic [N_REQ-1:0]       gnt,
  output logic                   fifo_wr_en,
  output DATA_TYPE               fifo_wr_data,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t     state;
  logic [IW-1:0]  owner;
  logic [IW-1:0]  rr_ptr;
  logic [CW-1:0]  cnt;

  logic           pick_valid;
  logic [IW-1:0]  pick_idx;
  logic           owner_req;
  logic           write_ok;
  logic           last_word;
  logic           exit_own;
  logic [IW-1:0]  next_ptr;

  // Winner search is only consumed in ARB_IDLE; other requesters are
  // ignored while someone owns the port.
  rr_pick #(.N(N_REQ)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // A write happens only when the owner still has a word and the FIFO can
  // take it, so the FIFO can never be overflowed by this block.
  assign owner_req = req[owner];
  assign write_ok  = (state == ARB_OWN) && owner_req && !fifo_full;
  assign last_word = write_ok && (cnt == CW'(MAX_BURST - 1));
  assign exit_own  = (state == ARB_OWN) && (!owner_req || last_word);
  assign next_ptr  = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;

  // Output muxing: one-hot grant to the owner, data forced to zero when idle
  // so the FIFO data pins do not toggle on non-write cycles.
  always_comb begin
    gnt = '0;
    if (write_ok) begin
      gnt[owner] = 1'b1;
    end
  end

  assign fifo_wr_en   = write_ok;
  assign fifo_wr_data = write_ok ? req_data[owner] : DATA_TYPE'('0);
  assign busy         = (state == ARB_OWN);

  // Arbitration FSM. ARB_IDLE latches the round-robin winner and restarts the
  // burst count; ARB_OWN counts written words and returns to idle when the
  // owner withdraws or its burst budget is used up. Backpressure only holds
  // the state, it never ends ownership.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state <= ARB_OWN;
            owner <= pick_idx;
            cnt   <= '0;
          end
        end
        ARB_OWN: begin
          if (write_ok) begin
            cnt <= cnt + 1'b1;
          end
          if (exit_own) begin
            state  <= ARB_IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q;

  // Stall statistic: cycles in which the owner had a word ready but the FIFO
  // was full. Saturates instead of wrapping so long runs stay meaningful.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((state == ARB_OWN) && owner_req && fifo_full && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter (N_REQ=4, MAX_BURST=4, 8-bit
//   words). A behavioural model tracks who owns the port, how many words it
//   has written in its grant and where the round-robin search starts next;
//   DUT outputs are compared against it every cycle at the falling edge.
//   Directed scenarios are followed by a randomized phase.
//   Honours FIFO_WR_ARB_STATS_EN for the stall statistic.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N_REQ     = 4;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  req_data [N_REQ];
  logic        fifo_full;
  logic [3:0]  gnt;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        busy;
  logic [15:0] stall_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  bit m_owned;
  int m_owner;
  int m_words;
  int m_ptr;
  int m_stall;

  // Words actually written by the DUT, and per-cycle observed grant
  logic [7:0] fifo_q [$];
  logic [3:0] last_gnt;

  fifo_wr_arbiter #(
    .DATA_TYPE (logic [7:0]),
    .N_REQ     (N_REQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .fifo_full    (fifo_full),
    .gnt          (gnt),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .busy         (busy),
    .stall_cnt    (stall_cnt)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owned = 1'b0;
    m_owner = 0;
    m_words = 0;
    m_ptr   = 0;
    m_stall = 0;
  endtask

  // Compare all outputs against the model, then log what the DUT wrote
  task automatic check_output();
    logic [3:0]  e_gnt;
    logic [7:0]  e_data;
    logic [15:0] e_stall;
    e_gnt = 4'b0000;
    if (m_owned && req[m_owner] && !fifo_full) e_gnt[m_owner] = 1'b1;
    e_data = (e_gnt != 4'b0000) ? req_data[m_owner] : 8'h00;
`ifdef FIFO_WR_ARB_STATS_EN
    e_stall = 16'(m_stall);
`else
    e_stall = 16'h0;
`endif
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("wr_en", 32'(fifo_wr_en), 32'(e_gnt != 4'b0000));
    check("wr_data", 32'(fifo_wr_data), 32'(e_data));
    check("busy", 32'(busy), 32'(m_owned));
    check("stall_cnt", 32'(stall_cnt), 32'(e_stall));
    last_gnt = gnt;
    if (fifo_wr_en === 1'b1) fifo_q.push_back(fifo_wr_data);
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    if (!m_owned) begin
      if (req != 4'b0000) begin
        for (int k = N_REQ - 1; k >= 0; k--) begin
          if (req[(m_ptr + k) % N_REQ]) m_owner = (m_ptr + k) % N_REQ;
        end
        m_owned = 1'b1;
        m_words = 0;
      end
    end else begin
      if (req[m_owner] && fifo_full && m_stall < 65535) m_stall++;
      if (!req[m_owner]) begin
        m_owned = 1'b0;
        m_ptr   = (m_owner + 1) % N_REQ;
      end else if (!fifo_full) begin
        m_words++;
        if (m_words == MAX_BURST) begin
          m_owned = 1'b0;
          m_ptr   = (m_owner + 1) % N_REQ;
        end
      end
    end
  endtask

  // One cycle: inputs are already applied; check at negedge, then clock
  task automatic apply_stimulus();
    @(negedge clk);
    check_output();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #10;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] t1_pat [10];
    int         burst_owner [$];
    int         grants;
    logic [3:0] prev_gnt;

    t1_pat = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4};
    reset     = 1'b1;
    req       = 4'b0000;
    fifo_full = 1'b0;
    for (int i = 0; i < N_REQ; i++) req_data[i] = 8'h00;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    check("rst_wr_data", 32'(fifo_wr_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stall", 32'(stall_cnt), 32'h0);
    reset = 1'b0;

    // Scenario 1: single requester, bursts of four separated by a bubble
    $display("[TB] scenario 1: single requester bursts");
    req = 4'b0100;
    req_data[2] = 8'hA5;
    fifo_q.delete();
    for (int i = 0; i < 10; i++) begin
      apply_stimulus();
      check("s1_pattern", 32'(last_gnt), 32'(t1_pat[i]));
    end
    check("s1_fifo_words", 32'(fifo_q.size()), 32'd8);
    for (int i = 0; i < fifo_q.size(); i++) check("s1_fifo_data", 32'(fifo_q[i]), 32'hA5);
    req = 4'b0000;
    apply_stimulus();

    // Scenario 2: everyone requesting, owners rotate 0,1,2,3,0
    $display("[TB] scenario 2: all requesting");
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N_REQ; i++) req_data[i] = 8'(8'h10 + i);
    prev_gnt = 4'b0000;
    for (int c = 0; c < 25; c++) begin
      apply_stimulus();
      if (prev_gnt == 4'b0000 && last_gnt != 4'b0000) begin
        for (int i = 0; i < N_REQ; i++) if (last_gnt[i]) burst_owner.push_back(i);
      end
      prev_gnt = last_gnt;
    end
    check("s2_bursts", 32'(burst_owner.size()), 32'd5);
    for (int i = 0; i < 5 && i < burst_owner.size(); i++)
      check("s2_order", 32'(burst_owner[i]), 32'(i % N_REQ));
    req = 4'b0000;
    apply_stimulus();

    // Scenario 3: owner 1 stalled by full for three cycles mid-burst
    $display("[TB] scenario 3: backpressure");
    do_reset();
    req = 4'b0010;
    req_data[1] = 8'h3C;
    grants = 0;
    for (int c = 0; c < 8; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      apply_stimulus();
      if (last_gnt != 4'b0000) grants++;
      if (fifo_full) check("s3_full_gnt", 32'(last_gnt), 32'h0);
    end
    fifo_full = 1'b0;
    check("s3_words", 32'(grants), 32'd4);
`ifdef FIFO_WR_ARB_STATS_EN
    check("s3_stall", 32'(stall_cnt), 32'd3);
`else
    check("s3_stall", 32'(stall_cnt), 32'd0);
`endif
    req = 4'b0000;
    apply_stimulus();

    // Scenario 4: owner 0 withdraws after two words, requester 2 is next
    $display("[TB] scenario 4: early release");
    do_reset();
    req = 4'b0001;
    req_data[0] = 8'h5A;
    req_data[2] = 8'hC3;
    repeat (3) apply_stimulus();
    req = 4'b0100;
    apply_stimulus();
    check("s4_release_gnt", 32'(last_gnt), 32'h0);
    apply_stimulus();
    check("s4_bubble", 32'(last_gnt), 32'h0);
    apply_stimulus();
    check("s4_next_owner", 32'(last_gnt), 32'h4);
    req = 4'b0000;
    repeat (2) apply_stimulus();

    // Scenario 5: asynchronous reset between clock edges mid-burst
    $display("[TB] scenario 5: async reset");
    do_reset();
    req = 4'b1111;
    repeat (3) apply_stimulus();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("s5_gnt", 32'(gnt), 32'h0);
    check("s5_wr_en", 32'(fifo_wr_en), 32'h0);
    check("s5_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    req   = 4'b1010;
    reset = 1'b0;
    apply_stimulus();
    apply_stimulus();
    check("s5_first_owner", 32'(last_gnt), 32'h2);
    req = 4'b0000;
    repeat (2) apply_stimulus();

    // Scenario 6: only requester 3, pointer wraps to 0 afterwards
    $display("[TB] scenario 6: pointer wrap");
    do_reset();
    req = 4'b1000;
    req_data[3] = 8'h77;
    for (int c = 0; c < 5; c++) begin
      apply_stimulus();
      if (c > 0) check("s6_owner3", 32'(last_gnt), 32'h8);
    end
    req = 4'b1111;
    apply_stimulus();
    apply_stimulus();
    check("s6_wrap", 32'(last_gnt), 32'h1);
    req = 4'b0000;
    repeat (4) apply_stimulus();

    // Randomized phase
    $display("[TB] random phase");
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req       = 4'($urandom_range(0, 15));
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N_REQ; i++) req_data[i] = 8'($urandom);
      apply_stimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
